// File: rtl/jk_reg_counter.sv
// rtl/jk_reg_counter.sv - WIDTH-bit JK flop bank with JK, modulo up/down and load modes
module jk_reg_counter #(
    parameter int              WIDTH     = 4,
    parameter longint unsigned MODULUS   = 64'd1 << WIDTH,
    parameter longint unsigned RESET_VAL = 64'd0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             tc
);
    localparam logic [1:0] MODE_JK   = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;

    localparam longint unsigned MOD_M1 = MODULUS - 64'd1;
    localparam logic [WIDTH:0]   MOD_X  = MODULUS[WIDTH:0];
    localparam logic [WIDTH:0]   MAX_X  = MOD_M1[WIDTH:0];
    localparam logic [WIDTH-1:0] MAX_V  = MOD_M1[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_V  = RESET_VAL[WIDTH-1:0];

    logic             at_top;
    logic             at_bot;
    logic             load_ok;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] j_eff;
    logic [WIDTH-1:0] k_eff;

    function automatic logic [WIDTH-1:0] jk_next(
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] jv,
        input logic [WIDTH-1:0] kv
    );
        return (jv & ~cur) | (~kv & cur);
    endfunction

    // Out-of-range states (only reachable via JK mode) are treated as wrap points.
    assign at_top  = {1'b0, q} >= MAX_X;
    assign at_bot  = (q == '0) || ({1'b0, q} >= MOD_X);
    assign load_ok = {1'b0, load_val} < MOD_X;

    always_comb begin
        target = q;
        j_eff  = j;
        k_eff  = k;
        if (mode != MODE_JK) begin
            case (mode)
                MODE_UP:   target = at_top ? '0 : q + WIDTH'(1);
                MODE_DOWN: target = at_bot ? MAX_V : q - WIDTH'(1);
                default:   target = load_ok ? load_val : MAX_V;
            endcase
            // Toggle mask: J=K=1 exactly on the bits that must change.
            j_eff = q ^ target;
            k_eff = q ^ target;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RST_V;
        end else if (en) begin
            q <= jk_next(q, j_eff, k_eff);
        end
    end

    assign qb = ~q;
    assign tc = en & ~reset & (((mode == MODE_UP) & at_top) | ((mode == MODE_DOWN) & at_bot));

endmodule

// File: tb/tb_jk_reg_counter.sv
// tb/tb_jk_reg_counter.sv - self-checking bench for jk_reg_counter (WIDTH=4, MODULUS=10, RESET_VAL=3)
module tb_jk_reg_counter;
    localparam int W   = 4;
    localparam int MOD = 10;
    localparam int RV  = 3;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] j = '0;
    logic [W-1:0] k = '0;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] q;
    logic [W-1:0] qb;
    logic         tc;

    int checks = 0;
    int passed = 0;
    int model_q = RV;
    bit done = 1'b0;

    jk_reg_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .q(q), .qb(qb), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic int model_next(input int cur);
        int r;
        r = cur;
        case (mode)
            2'b00: begin
                r = 0;
                for (int b = 0; b < W; b++) begin
                    int cb;
                    cb = (cur >> b) & 1;
                    case ({j[b], k[b]})
                        2'b00: r += cb << b;
                        2'b01: r += 0;
                        2'b10: r += 1 << b;
                        default: r += (1 - cb) << b;
                    endcase
                end
            end
            2'b01: r = (cur >= MOD - 1) ? 0 : cur + 1;
            2'b10: r = (cur == 0 || cur >= MOD) ? MOD - 1 : cur - 1;
            default: r = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
        endcase
        return r;
    endfunction

    function automatic int model_tc();
        if (!en || reset) return 0;
        if (mode == 2'b01) return (model_q >= MOD - 1) ? 1 : 0;
        if (mode == 2'b10) return (model_q == 0 || model_q >= MOD) ? 1 : 0;
        return 0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_q = RV;
        else if (en) model_q = model_next(model_q);
    end

    always @(negedge clk) begin
        if (!done) begin
            chk("model_q", int'(q), model_q);
            chk("model_qb", int'(qb), (~model_q) & 15);
            chk("model_tc", int'(tc), model_tc());
        end
    end

    task automatic step(input logic e, input logic [1:0] m,
                        input logic [W-1:0] jv, input logic [W-1:0] kv,
                        input logic [W-1:0] lv);
        en = e; mode = m; j = jv; k = kv; load_val = lv;
        @(posedge clk);
        #2;
    endtask

    task automatic set_mode(input logic [1:0] m);
        en = 1'b1; mode = m;
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        chk("reset_q", int'(q), 3);
        chk("reset_qb", int'(qb), 12);
        chk("reset_tc", int'(tc), 0);
        reset = 1'b0;
        @(posedge clk); #2;
        chk("release_hold", int'(q), 3);

        // Up-count wrap from 7
        step(1, 2'b11, '0, '0, 4'd7);
        chk("load7", int'(q), 7);
        set_mode(2'b01); chk("up_tc_at7", int'(tc), 0);
        step(1, 2'b01, '0, '0, '0); chk("up_8", int'(q), 8); chk("up_tc_at8", int'(tc), 0);
        step(1, 2'b01, '0, '0, '0); chk("up_9", int'(q), 9); chk("up_tc_at9", int'(tc), 1);
        step(1, 2'b01, '0, '0, '0); chk("up_0", int'(q), 0); chk("up_tc_at0", int'(tc), 0);
        step(1, 2'b01, '0, '0, '0); chk("up_1", int'(q), 1);

        // Down-count wrap from 1
        set_mode(2'b10); chk("dn_tc_at1", int'(tc), 0);
        step(1, 2'b10, '0, '0, '0); chk("dn_0", int'(q), 0); chk("dn_tc_at0", int'(tc), 1);
        step(1, 2'b10, '0, '0, '0); chk("dn_9", int'(q), 9); chk("dn_tc_at9", int'(tc), 0);
        step(1, 2'b10, '0, '0, '0); chk("dn_8", int'(q), 8);

        // JK per bit: reach 1010, then j=0101 k=1001 -> 0111
        step(1, 2'b00, 4'b1010, 4'b0101, '0); chk("jk_1010", int'(q), 10);
        set_mode(2'b00); chk("jk_tc", int'(tc), 0);
        step(1, 2'b00, 4'b0101, 4'b1001, '0); chk("jk_0111", int'(q), 7);

        // Out-of-range handling
        step(1, 2'b00, 4'b1110, 4'b0001, '0); chk("jk_14", int'(q), 14);
        set_mode(2'b01); chk("oor_up_tc", int'(tc), 1);
        step(1, 2'b01, '0, '0, '0); chk("oor_up_0", int'(q), 0);
        step(1, 2'b00, 4'b1110, 4'b0001, '0); chk("jk_14b", int'(q), 14);
        set_mode(2'b10); chk("oor_dn_tc", int'(tc), 1);
        step(1, 2'b10, '0, '0, '0); chk("oor_dn_9", int'(q), 9);
        step(1, 2'b11, 4'b1111, 4'b1111, 4'd12); chk("load12_sat", int'(q), 9);
        step(1, 2'b11, '0, '0, 4'd5); chk("load5", int'(q), 5);
        step(1, 2'b11, '0, '0, 4'd15); chk("load15_sat", int'(q), 9);

        // Enable gating at q=9, where up-mode tc would otherwise fire
        for (int m = 0; m < 4; m++) begin
            for (int c = 0; c < 3; c++) begin
                step(0, 2'(m), 4'b1111, 4'b0110, 4'd2);
                chk("gate_q", int'(q), 9);
                chk("gate_tc", int'(tc), 0);
            end
        end

        // Reset pulse mid up-count
        step(1, 2'b11, '0, '0, 4'd0);
        step(1, 2'b01, '0, '0, '0);
        step(1, 2'b01, '0, '0, '0); chk("pre_rst_2", int'(q), 2);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_q", int'(q), 3);
        chk("async_rst_tc", int'(tc), 0);
        @(posedge clk); #2;
        chk("rst_held_q", int'(q), 3);
        reset = 1'b0;
        step(1, 2'b01, '0, '0, '0); chk("resume_4", int'(q), 4);
        step(1, 2'b01, '0, '0, '0); chk("resume_5", int'(q), 5);

        @(negedge clk);
        #1;
        done = 1'b1;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/jk_reg_counter.md
Name: jk_reg_counter

Overview:
- Parametrised successor to the single-bit JK flip-flop: a WIDTH-bit bank of JK flops with a shared clock and reset.
- Runs in one of four modes: per-bit JK, modulo up-count, modulo down-count, or parallel load.
- Count modes drive internal per-bit J=K toggle masks, so every state change goes through JK semantics.
- Used as a general register/counter primitive in the teaching and iverilog designs.

Parameters:
- WIDTH, 4, number of JK bits in the bank (1..32).
- MODULUS, 2**WIDTH, count modulus (2..2**WIDTH); count range is 0..MODULUS-1.
- RESET_VAL, 0, value of q on reset; must be < MODULUS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  clock enable. When low, q holds in all modes.
- mode  input  2  operating mode: 00 JK, 01 up, 10 down, 11 load.
- j  input  WIDTH  per-bit J inputs (mode 00 only).
- k  input  WIDTH  per-bit K inputs (mode 00 only).
- load_val  input  WIDTH  parallel load data (mode 11 only).
- q  output  WIDTH  registered state.
- qb  output  WIDTH  always ~q (combinational).
- tc  output  1  terminal-count/wrap indicator (combinational).

Behaviour:
- Reset: asynchronous, active-high.
  - While reset=1: q=RESET_VAL, qb=~RESET_VAL, tc=0, regardless of clk.
  - Release takes effect on the next rising clk edge. No other output is reset-dependent.
- All state updates occur on posedge clk when reset=0 and en=1. With en=0, q holds and tc=0.
- Mode 00 (JK), per bit i, {j[i],k[i]}:
  - 00: hold.
  - 01: clear.
  - 10: set.
  - 11: toggle.
  - Bits are independent. The result may exceed MODULUS-1; this is permitted in this mode.
- Mode 01 (up):
  - If q >= MODULUS-1, next q=0 (wrap).
  - Otherwise next q=q+1.
- Mode 10 (down):
  - If q==0 or q >= MODULUS, next q=MODULUS-1 (wrap).
  - Otherwise next q=q-1.
- Count-mode implementation:
  - Compute target value t, then toggle mask m = q ^ t.
  - Apply per-bit J=K=m[i], which must equal direct assignment of t.
  - Arithmetic is WIDTH bits, unsigned. No carry escapes the bank.
- Mode 11 (load):
  - If load_val < MODULUS, next q=load_val.
  - Otherwise next q=MODULUS-1 (saturate).
  - j/k are ignored.
- tc = en & ~reset & one of:
  - mode==01 and q >= MODULUS-1, or
  - mode==10 and (q==0 or q >= MODULUS).
  - tc is high in the cycle before the clock edge that wraps; it is 0 in modes 00 and 11.
- Mode changes are allowed on any cycle. The new mode applies at the next edge with no pipeline.
- Latency: q reflects inputs one clock after sampling. qb and tc are combinational from q/mode/en.
- Reset asserted mid-count: q goes to RESET_VAL immediately. Counting resumes from RESET_VAL after release.
- MODULUS == 2**WIDTH: up wraps naturally at all-ones, and the q >= MODULUS branch is unreachable.

Test Plan:
- Reset: WIDTH=4, MODULUS=10, RESET_VAL=3. Assert reset between edges -> q=3 and qb=4'b1100 immediately, with no clk edge.
- Up-count wrap: en=1, mode=01 from q=7 -> q steps 8, 9, 0, 1. tc=1 only while q=9.
- Down-count wrap: mode=10 from q=1 -> q steps 0, 9, 8. tc=1 only while q=0.
- JK per bit: q=4'b1010, j=4'b0101, k=4'b1001 -> q=4'b0111 (bit3 clear, bit2 set, bit1 hold, bit0 toggle).
- Out-of-range handling:
  - Mode 00 sets q=4'b1110 (14).
  - Mode 01 then gives q=0 with tc=1 beforehand.
  - Set q=14 again; mode 10 gives q=9.
  - Mode 11 with load_val=12 gives q=9; with load_val=5 gives q=5.
- Enable gating: en=0 in every mode for 3 clocks -> q unchanged and tc=0. Reset pulse mid up-count -> q=RESET_VAL, then counting resumes from RESET_VAL+1.
